// File: rtl/raw_pixel_capture.sv
// Sensor-timing front end: turns FVAL/LVAL + raw pixel bus into the
// DATA/DVAL/X/Y stream used by the Bayer stage, with start/stop gating and error flags.
module raw_pixel_capture #(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned COLUMN_WIDTH = 1280,
    parameter int unsigned ROW_HEIGHT   = 960,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FRAME_W      = 32
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DATA_W-1:0]  iDATA,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic               iSTART,
    input  logic               iEND,
    output logic [DATA_W-1:0]  oDATA,
    output logic               oDVAL,
    output logic [CNT_W-1:0]   oX_Cont,
    output logic [CNT_W-1:0]   oY_Cont,
    output logic [FRAME_W-1:0] oFrame_Cont,
    output logic               oFRAME_DONE,
    output logic               oBUSY,
    output logic               oLINE_ERR,
    output logic               oOVERFLOW
);

    // Row counter needs one extra bit so it can sit at ROW_HEIGHT after the last line.
    localparam int unsigned X_W = CNT_W;
    localparam int unsigned Y_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic                 stop_pending_q, stop_pending_d;
    logic                 fval_q, lval_q;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 dval_q, dval_d;
    logic [CNT_W-1:0]     xo_q, xo_d;
    logic [CNT_W-1:0]     yo_q, yo_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 line_err_q, line_err_d;
    logic                 ovf_q, ovf_d;

    logic fval_rise_c, fval_fall_c, lval_fall_c;

    assign fval_rise_c = iFVAL & ~fval_q;
    assign fval_fall_c = ~iFVAL & fval_q;
    assign lval_fall_c = ~iLVAL & lval_q;

    // State, position and registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q        <= IDLE;
            x_q            <= '0;
            y_q            <= '0;
            stop_pending_q <= 1'b0;
            fval_q         <= 1'b0;
            lval_q         <= 1'b0;
            data_q         <= '0;
            dval_q         <= 1'b0;
            xo_q           <= '0;
            yo_q           <= '0;
            frame_q        <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            line_err_q     <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            stop_pending_q <= stop_pending_d;
            fval_q         <= iFVAL;
            lval_q         <= iLVAL;
            data_q         <= data_d;
            dval_q         <= dval_d;
            xo_q           <= xo_d;
            yo_q           <= yo_d;
            frame_q        <= frame_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            line_err_q     <= line_err_d;
            ovf_q          <= ovf_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        stop_pending_d = stop_pending_q;
        data_d         = data_q;
        dval_d         = 1'b0;
        xo_d           = xo_q;
        yo_d           = yo_q;
        frame_d        = frame_q;
        done_d         = 1'b0;
        line_err_d     = line_err_q;
        ovf_d          = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (iSTART && !iEND) begin
                    state_d    = ARMED;
                    line_err_d = 1'b0;
                    ovf_d      = 1'b0;
                end
            end

            ARMED: begin
                // Only a fresh rising edge starts capture, so a frame already in flight is skipped.
                if (iEND) begin
                    state_d = IDLE;
                end else if (fval_rise_c) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                end
            end

            CAPTURE: begin
                if (iEND) begin
                    stop_pending_d = 1'b1;
                end
                if (fval_fall_c) begin
                    done_d  = 1'b1;
                    frame_d = frame_q + FRAME_W'(1);
                    x_d     = '0;
                    y_d     = '0;
                    if (stop_pending_q || iEND) begin
                        state_d        = IDLE;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = ARMED;
                    end
                end else if (iFVAL && iLVAL) begin
                    if (y_q < Y_W'(ROW_HEIGHT)) begin
                        data_d = iDATA;
                        dval_d = 1'b1;
                        xo_d   = x_q;
                        yo_d   = y_q[CNT_W-1:0];
                        if (x_q == X_W'(COLUMN_WIDTH - 1)) begin
                            x_d = '0;
                            y_d = y_q + Y_W'(1);
                        end else begin
                            x_d = x_q + X_W'(1);
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (lval_fall_c && (x_q != '0)) begin
                    // Full lines have already wrapped to column 0; anything else is short.
                    x_d        = '0;
                    y_d        = y_q + Y_W'(1);
                    line_err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = xo_q;
    assign oY_Cont     = yo_q;
    assign oFrame_Cont = frame_q;
    assign oFRAME_DONE = done_q;
    assign oBUSY       = busy_q;
    assign oLINE_ERR   = line_err_q;
    assign oOVERFLOW   = ovf_q;

endmodule
